// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes opcode/funct3/funct7[5] into the 4-bit ALU control
// code, selects operands and registers them for the execute-stage ALU.
// A main entry drives the outputs and a skid entry absorbs one extra
// instruction so backpressure never drops or duplicates work.
// Optional macro ALU_ISSUE_PERFCNT_EN adds issue_cnt/stall_cnt counters.
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [3:0]            ALUctrl,
    output logic                  is_branch,
    output logic                  illegal
`ifdef ALU_ISSUE_PERFCNT_EN
    ,
    output logic [31:0]           issue_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [3:0]            ctrl;
        logic                  branch;
        logic                  illegal;
    } entry_t;

    logic [2:0]            f3_code;
    logic [3:0]            dec_ctrl;
    logic                  dec_branch;
    logic                  dec_illegal;
    logic                  use_rs2;
    logic [DATA_WIDTH-1:0] dec_op2;
    entry_t                dec_entry;

    entry_t main_reg, main_next;
    entry_t skid_reg, skid_next;
    logic   main_valid_reg, main_valid_next;
    logic   skid_valid_reg, skid_valid_next;

    logic accept;
    logic emit;

    // Map an OP/OP-IMM funct3 onto the ALU's compact operation code
    always_comb begin
        f3_code = 3'b000;
        case (funct3)
            3'b000:  f3_code = 3'b000; // ADD/SUB
            3'b001:  f3_code = 3'b001; // SLL
            3'b111:  f3_code = 3'b010; // AND
            3'b110:  f3_code = 3'b011; // OR
            3'b100:  f3_code = 3'b100; // XOR
            3'b010:  f3_code = 3'b101; // SLT
            3'b011:  f3_code = 3'b101; // SLTU shares the compare unit
            3'b101:  f3_code = 3'b110; // SRL/SRA
            default: f3_code = 3'b000;
        endcase
    end

    // Opcode decode: control code, operand-2 source, branch and illegal flags
    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        use_rs2     = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs2  = 1'b1;
                dec_ctrl = {funct7_5, f3_code};
            end
            OPC_OP_IMM: begin
                // funct7[5] only distinguishes SRAI from SRLI; on other
                // immediates that bit is immediate data, not an opcode bit
                dec_ctrl = {funct7_5 & (funct3 == 3'b101), f3_code};
            end
            OPC_BRANCH: begin
                use_rs2     = 1'b1;
                dec_branch  = 1'b1;
                dec_ctrl    = {1'b0, funct3};
                dec_illegal = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                dec_ctrl = 4'b0000;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Per-bit operand-2 select between register read and immediate
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_op2_sel
            assign dec_op2[gi] = use_rs2 ? rs2_data[gi] : imm[gi];
        end
    endgenerate

    assign dec_entry = '{op1: rs1_data, op2: dec_op2, ctrl: dec_ctrl,
                         branch: dec_branch, illegal: dec_illegal};

    assign in_ready  = ~skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign accept    = in_valid & in_ready;
    assign emit      = main_valid_reg & out_ready;

    // Two-entry buffer steering: flush wins, skid refills main on emit
    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (emit) begin
            if (skid_valid_reg) begin
                // in_ready is low here, so no new accept can collide
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next = dec_entry;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg) begin
                main_next       = dec_entry;
                main_valid_next = 1'b1;
            end else begin
                skid_next       = dec_entry;
                skid_valid_next = 1'b1;
            end
        end
    end

    // Buffer state registers; reset also zeroes the payload so outputs read 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign ALUop1    = main_reg.op1;
    assign ALUop2    = main_reg.op2;
    assign ALUctrl   = main_reg.ctrl;
    assign is_branch = main_reg.branch;
    assign illegal   = main_reg.illegal;

`ifdef ALU_ISSUE_PERFCNT_EN
    logic [31:0] issue_cnt_reg;
    logic [31:0] stall_cnt_reg;

    // Handshake and stall counters; flush does not touch them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_reg <= 32'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            if (emit)
                issue_cnt_reg <= issue_cnt_reg + 32'd1;
            if (main_valid_reg && !out_ready)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign issue_cnt = issue_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed test-plan steps followed by random
// traffic, compared against a queue-based model of the issue buffer.
module tb_alu_issue_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUop1;
    logic [31:0] ALUop2;
    logic [3:0]  ALUctrl;
    logic        is_branch;
    logic        illegal;
`ifdef ALU_ISSUE_PERFCNT_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic        br;
        logic        ill;
    } ent_t;

    ent_t        q[$];
    int unsigned exp_issue;
    int unsigned exp_stall;
    int          errors = 0;
    int          checks = 0;

    alu_issue_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .is_branch(is_branch), .illegal(illegal)
`ifdef ALU_ISSUE_PERFCNT_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the rules as arithmetic
    function automatic ent_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic f7, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] im);
        int unsigned code_of_f3 [8];
        ent_t e;
        code_of_f3 = '{0, 1, 5, 5, 4, 6, 3, 2};
        e.op1  = a;
        e.op2  = (opc == OP || opc == BRANCH) ? b : im;
        e.br   = (opc == BRANCH);
        e.ill  = 1'b0;
        e.ctrl = 4'd0;
        if (opc == OP)
            e.ctrl = 4'(code_of_f3[f3] + (f7 ? 8 : 0));
        else if (opc == OPIMM)
            e.ctrl = 4'(code_of_f3[f3] + ((f7 && f3 == 3'd5) ? 8 : 0));
        else if (opc == BRANCH) begin
            e.ctrl = {1'b0, f3};
            e.ill  = (f3 == 3'd2 || f3 == 3'd3);
        end else if (opc != LOAD && opc != STORE && opc != JALR)
            e.ill = 1'b1;
        return e;
    endfunction

    // Compare the DUT against the model; called at a negedge
    task automatic compare_state(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check({tag, ".op1"}, 64'(ALUop1), 64'(q[0].op1));
            check({tag, ".op2"}, 64'(ALUop2), 64'(q[0].op2));
            check({tag, ".ctrl"}, 64'(ALUctrl), 64'(q[0].ctrl));
            check({tag, ".br"}, 64'(is_branch), 64'(q[0].br));
            check({tag, ".ill"}, 64'(illegal), 64'(q[0].ill));
        end
`ifdef ALU_ISSUE_PERFCNT_EN
        check({tag, ".issue_cnt"}, 64'(issue_cnt), 64'(exp_issue));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check
    task automatic step(input string tag, input logic v, input logic [6:0] opc,
                        input logic [2:0] f3, input logic f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic ordy, input logic fl);
        bit acc;
        bit emt;
        in_valid = v; opcode = opc; funct3 = f3; funct7_5 = f7;
        rs1_data = a; rs2_data = b; imm = im; out_ready = ordy; flush = fl;
        acc = v && (q.size() < 2);
        emt = ordy && (q.size() > 0);
        @(posedge clk);
        if (emt) exp_issue++;
        if (q.size() > 0 && !ordy) exp_stall++;
        if (fl) q.delete();
        else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(opc, f3, f7, a, b, im));
        end
        @(negedge clk);
        compare_state(tag);
        $display("step %s v=%0b opc=%b f3=%0d ordy=%0b fl=%0b -> depth=%0d",
                 tag, v, opc, f3, ordy, fl, q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".op1"}, 64'(ALUop1), 64'd0);
        check({tag, ".op2"}, 64'(ALUop2), 64'd0);
        check({tag, ".ctrl"}, 64'(ALUctrl), 64'd0);
        check({tag, ".br"}, 64'(is_branch), 64'd0);
        check({tag, ".ill"}, 64'(illegal), 64'd0);
`ifdef ALU_ISSUE_PERFCNT_EN
        check({tag, ".issue_cnt"}, 64'(issue_cnt), 64'd0);
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    initial begin
        logic [6:0] opc_list [8];
        logic [6:0] ropc;
        opc_list = '{OP, OPIMM, BRANCH, LOAD, STORE, JALR, LUI, 7'b0};
        exp_issue = 0; exp_stall = 0;
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0; flush = 1'b0; out_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // SUB
        step("sub", 1, OP, 3'b000, 1, 32'd10, 32'd3, 32'd77, 1, 0);
        check("sub.ctrl_const", 64'(ALUctrl), 64'b1000);
        check("sub.op1_const", 64'(ALUop1), 64'd10);
        check("sub.op2_const", 64'(ALUop2), 64'd3);
        check("sub.ill_const", 64'(illegal), 64'd0);

        // SRAI then ANDI with funct7_5 set
        step("srai", 1, OPIMM, 3'b101, 1, 32'd5, 32'd9, 32'd4, 1, 0);
        check("srai.ctrl_const", 64'(ALUctrl), 64'b1110);
        check("srai.op2_const", 64'(ALUop2), 64'd4);
        step("andi", 1, OPIMM, 3'b111, 1, 32'd5, 32'd9, 32'd4, 1, 0);
        check("andi.ctrl_const", 64'(ALUctrl), 64'b0010);

        // BGEU, then an illegal branch funct3
        step("bgeu", 1, BRANCH, 3'b111, 0, 32'd1, 32'hFFFF_FFFF, 32'd8, 1, 0);
        check("bgeu.ctrl_const", 64'(ALUctrl), 64'b0111);
        check("bgeu.br_const", 64'(is_branch), 64'd1);
        check("bgeu.op2_const", 64'(ALUop2), 64'hFFFF_FFFF);
        step("br010", 1, BRANCH, 3'b010, 0, 32'd1, 32'd2, 32'd8, 1, 0);
        check("br010.ill_const", 64'(illegal), 64'd1);

        // Unsupported opcode is still passed downstream
        step("lui", 1, LUI, 3'b011, 1, 32'd6, 32'd7, 32'h1000, 1, 0);
        check("lui.ill_const", 64'(illegal), 64'd1);
        check("lui.ctrl_const", 64'(ALUctrl), 64'd0);
        step("drain0", 0, OP, 0, 0, 0, 0, 0, 1, 0);

        // Backpressure: A to main, B to skid, hold, then drain in order
        step("bpA", 1, OP, 3'b110, 0, 32'hA1, 32'hA2, 0, 0, 0);
        step("bpB", 1, OP, 3'b100, 0, 32'hB1, 32'hB2, 0, 0, 0);
        check("bp.in_ready_low", 64'(in_ready), 64'd0);
        step("bpC_blocked", 1, OP, 3'b001, 0, 32'hC1, 32'hC2, 0, 0, 0);
        step("bphold", 0, OP, 0, 0, 0, 0, 0, 0, 0);
        step("bpemitA", 0, OP, 0, 0, 0, 0, 0, 1, 0);
        check("bp.B_in_main", 64'(ALUop1), 64'hB1);
        step("bpemitB", 0, OP, 0, 0, 0, 0, 0, 1, 0);
        check("bp.empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and an incoming instruction
        step("flA", 1, LOAD, 0, 0, 32'h11, 0, 32'h22, 0, 0);
        step("flB", 1, STORE, 0, 0, 32'h33, 0, 32'h44, 0, 0);
        step("flush", 1, JALR, 0, 0, 32'h55, 0, 32'h66, 0, 1);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        step("postfl", 0, OP, 0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-stall
        step("rsA", 1, OP, 3'b000, 0, 32'hDEAD, 32'hBEEF, 0, 0, 0);
        step("rshold", 0, OP, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete(); exp_issue = 0; exp_stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ropc = opc_list[$urandom_range(0, 7)];
            if (ropc == 7'b0) ropc = 7'($urandom);
            step("rand", 1'($urandom_range(0, 3) != 0), ropc, 3'($urandom), 1'($urandom),
                 $urandom, $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
